// File: rtl/ila_cmd_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ila_cmd_pkg
// Brief    : Opcodes, error codes and FSM states for the ILA command sequencer.
// Revision : 1.0
// ============================================================================
package ila_cmd_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_START  = 4'h1;
  localparam logic [3:0] OP_RST    = 4'h2;
  localparam logic [3:0] OP_CFG_WR = 4'h3;
  localparam logic [3:0] OP_RD     = 4'h4;

  localparam logic [1:0] ERR_OPC = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PAY_HI = 2'd1,
    PAY_LO = 2'd2,
    ISSUE  = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ila_cmd_timeout.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ila_cmd_timeout
// Brief    : Inter-byte idle counter; expires on the cycle the count reaches
//            TIMEOUT_CYCLES-1.
// Revision : 1.0
// ============================================================================
module ila_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(TIMEOUT_CYCLES - 2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // An idle cycle that would bring the count to TIMEOUT_CYCLES-1 expires now.
  assign o_expire = i_en && !i_clr && (cnt_q == LAST_IDLE);

endmodule
`default_nettype wire

// File: rtl/ila_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ila_cmd_sequencer
// Brief    : Byte-level command decoder/sequencer for the ILA host interface.
// Revision : 1.0
// ============================================================================
module ila_cmd_sequencer
  import ila_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_byte_ready,
  output logic        o_cfg_valid,
  input  logic        i_cfg_ready,
  output logic [3:0]  o_cfg_addr,
  output logic [15:0] o_cfg_data,
  output logic        o_start,
  output logic        o_ila_rst,
  output logic        o_rd_req,
  output logic [3:0]  o_rd_addr,
  output logic        o_err,
  output logic [1:0]  o_err_code,
  output logic        o_busy
);

  state_e      state_q, state_d;
  logic [3:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        start_q, start_d;
  logic        ila_rst_q, ila_rst_d;
  logic        rd_req_q, rd_req_d;
  logic [3:0]  rd_addr_q, rd_addr_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        w_accept;
  logic [3:0]  w_opc;
  logic [3:0]  w_arg;
  logic        w_in_payload;
  logic        w_tmo_clr;
  logic        w_tmo_en;
  logic        w_tmo_expire;

  assign w_opc        = i_byte[7:4];
  assign w_arg        = i_byte[3:0];
  assign o_byte_ready = (state_q != ISSUE);
  assign w_accept     = i_byte_valid && o_byte_ready;
  assign w_in_payload = (state_q == PAY_HI) || (state_q == PAY_LO);

  // Clear on entry to the payload phase and on every payload byte.
  assign w_tmo_clr = w_accept &&
                     (((state_q == IDLE) && (w_opc == OP_CFG_WR)) || w_in_payload);
  assign w_tmo_en  = w_in_payload && !w_accept;

  ila_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_tmo_clr),
    .i_en     (w_tmo_en),
    .o_expire (w_tmo_expire)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    start_d    = 1'b0;
    ila_rst_d  = 1'b0;
    rd_req_d   = 1'b0;
    rd_addr_d  = rd_addr_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    case (state_q)
      IDLE: begin
        if (w_accept) begin
          case (w_opc)
            OP_NOP:    ;
            OP_START:  start_d = 1'b1;
            OP_RST:    ila_rst_d = 1'b1;
            OP_CFG_WR: begin
              addr_d  = w_arg;
              state_d = PAY_HI;
            end
            OP_RD: begin
              rd_req_d  = 1'b1;
              rd_addr_d = w_arg;
            end
            default: begin
              err_d      = 1'b1;
              err_code_d = ERR_OPC;
            end
          endcase
        end
      end
      PAY_HI: begin
        if (w_accept) begin
          data_d[15:8] = i_byte;
          state_d      = PAY_LO;
        end else if (w_tmo_expire) begin
          err_d      = 1'b1;
          err_code_d = ERR_TMO;
          state_d    = IDLE;
        end
      end
      PAY_LO: begin
        if (w_accept) begin
          data_d[7:0] = i_byte;
          state_d     = ISSUE;
        end else if (w_tmo_expire) begin
          err_d      = 1'b1;
          err_code_d = ERR_TMO;
          state_d    = IDLE;
        end
      end
      ISSUE: begin
        if (i_cfg_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      start_q    <= 1'b0;
      ila_rst_q  <= 1'b0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      start_q    <= start_d;
      ila_rst_q  <= ila_rst_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Valid is decoded from state so an asynchronous reset drops it at once.
  assign o_cfg_valid = (state_q == ISSUE);
  assign o_busy      = (state_q != IDLE);
  assign o_cfg_addr  = addr_q;
  assign o_cfg_data  = data_q;
  assign o_start     = start_q;
  assign o_ila_rst   = ila_rst_q;
  assign o_rd_req    = rd_req_q;
  assign o_rd_addr   = rd_addr_q;
  assign o_err       = err_q;
  assign o_err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_ila_cmd_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ila_cmd_sequencer
// Brief    : Scoreboard bench: directed scenarios plus random byte streams.
// Revision : 1.0
// ============================================================================
module tb_ila_cmd_sequencer;

  localparam int T = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_byte_valid = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        i_cfg_ready = 1'b0;
  logic        o_byte_ready;
  logic        o_cfg_valid;
  logic [3:0]  o_cfg_addr;
  logic [15:0] o_cfg_data;
  logic        o_start;
  logic        o_ila_rst;
  logic        o_rd_req;
  logic [3:0]  o_rd_addr;
  logic        o_err;
  logic [1:0]  o_err_code;
  logic        o_busy;

  ila_cmd_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_byte_valid (i_byte_valid),
    .i_byte       (i_byte),
    .o_byte_ready (o_byte_ready),
    .o_cfg_valid  (o_cfg_valid),
    .i_cfg_ready  (i_cfg_ready),
    .o_cfg_addr   (o_cfg_addr),
    .o_cfg_data   (o_cfg_data),
    .o_start      (o_start),
    .o_ila_rst    (o_ila_rst),
    .o_rd_req     (o_rd_req),
    .o_rd_addr    (o_rd_addr),
    .o_err        (o_err),
    .o_err_code   (o_err_code),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [2:0]  kind;
    logic [3:0]  addr;
    logic [15:0] data;
  } ev_t;

  localparam logic [2:0] K_START = 3'd1;
  localparam logic [2:0] K_RST   = 3'd2;
  localparam logic [2:0] K_RD    = 3'd3;
  localparam logic [2:0] K_ERR   = 3'd4;
  localparam logic [2:0] K_CFG   = 3'd5;

  ev_t sb[$];
  int  checks = 0;
  int  failures = 0;

  // Reference model: command progress as "collecting payload" / "waiting on bank".
  bit          m_in_cmd;
  bit          m_wait;
  int          m_idle;
  logic [3:0]  m_addr;
  logic [15:0] m_data;
  logic [1:0]  m_code;
  logic [7:0]  m_pay[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_in_cmd = 0;
    m_wait   = 0;
    m_idle   = 0;
    m_addr   = '0;
    m_data   = '0;
    m_code   = '0;
    m_pay.delete();
  endtask

  task automatic model_step(input logic v, input logic [7:0] b, input logic rdy);
    logic acc;
    acc = v && !m_wait;
    if (m_wait) begin
      if (rdy) begin
        sb.push_back(ev_t'{K_CFG, m_addr, m_data});
        m_wait = 0;
      end
    end else if (m_in_cmd) begin
      if (acc) begin
        m_pay.push_back(b);
        m_idle = 0;
        if (m_pay.size() == 2) begin
          m_data   = {m_pay[0], m_pay[1]};
          m_pay.delete();
          m_in_cmd = 0;
          m_wait   = 1;
        end
      end else begin
        m_idle++;
        if (m_idle == T - 1) begin
          sb.push_back(ev_t'{K_ERR, 4'd0, 16'd2});
          m_code   = 2'b10;
          m_in_cmd = 0;
          m_pay.delete();
        end
      end
    end else if (acc) begin
      case (b[7:4])
        4'h0: ;
        4'h1: sb.push_back(ev_t'{K_START, 4'd0, 16'd0});
        4'h2: sb.push_back(ev_t'{K_RST, 4'd0, 16'd0});
        4'h3: begin
          m_in_cmd = 1;
          m_addr   = b[3:0];
          m_idle   = 0;
          m_pay.delete();
        end
        4'h4: sb.push_back(ev_t'{K_RD, b[3:0], 16'd0});
        default: begin
          sb.push_back(ev_t'{K_ERR, 4'd0, 16'd1});
          m_code = 2'b01;
        end
      endcase
    end
  endtask

  // Called at posedge+1: check the state left by the last edge, then drive.
  task automatic cycle(input logic v, input logic [7:0] b, input logic rdy);
    i_byte_valid = v;
    i_byte       = b;
    i_cfg_ready  = rdy;
    chk("byte_ready", o_byte_ready, !m_wait);
    chk("busy", o_busy, m_in_cmd || m_wait);
    chk("cfg_valid", o_cfg_valid, m_wait);
    if (m_wait) chk("cfg_word", {o_cfg_addr, o_cfg_data}, {m_addr, m_data});
    chk("err_code", o_err_code, m_code);
    model_step(v, b, rdy);
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {o_cfg_valid, o_cfg_addr, o_cfg_data, o_start, o_ila_rst, o_rd_req,
            o_rd_addr, o_err, o_err_code, o_busy};
  endfunction

  task automatic do_reset();
    i_rst_n      = 1'b0;
    i_byte_valid = 1'b0;
    i_byte       = 8'h00;
    i_cfg_ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_outputs", all_outs(), 32'd0);
    chk("reset_byte_ready", o_byte_ready, 1);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  // Monitor: pops one expected event per observed strobe or handshake.
  ev_t act_ev;
  ev_t exp_ev;
  int  n_ev;
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      n_ev = int'(o_start) + int'(o_ila_rst) + int'(o_rd_req) + int'(o_err)
           + int'(o_cfg_valid && i_cfg_ready);
      if (n_ev > 1) begin
        chk("event_overlap", n_ev, 1);
      end else if (n_ev == 1) begin
        if (o_start)        act_ev = ev_t'{K_START, 4'd0, 16'd0};
        else if (o_ila_rst) act_ev = ev_t'{K_RST, 4'd0, 16'd0};
        else if (o_rd_req)  act_ev = ev_t'{K_RD, o_rd_addr, 16'd0};
        else if (o_err)     act_ev = ev_t'{K_ERR, 4'd0, {14'd0, o_err_code}};
        else                act_ev = ev_t'{K_CFG, o_cfg_addr, o_cfg_data};
        if (sb.size() == 0) begin
          chk("unexpected_event", act_ev, 0);
        end else begin
          exp_ev = sb.pop_front();
          chk("event", act_ev, exp_ev);
        end
      end
    end
  end

  initial begin
    logic [7:0] rb;
    do_reset();

    // Back-to-back strobes
    cycle(1, 8'h10, 0); cycle(1, 8'h20, 0); cycle(1, 8'h47, 0);
    repeat (2) cycle(0, 8'h00, 0);

    // Config write, bank ready on entry
    cycle(1, 8'h35, 1); cycle(1, 8'hAB, 1); cycle(1, 8'hCD, 1);
    repeat (2) cycle(0, 8'h00, 1);

    // Config write with stalled bank and a byte offered during ISSUE
    cycle(1, 8'h35, 0); cycle(1, 8'hAB, 0); cycle(1, 8'hCD, 0);
    repeat (10) cycle(1, 8'h10, 0);
    cycle(1, 8'h10, 1);
    cycle(1, 8'h10, 0);
    repeat (2) cycle(0, 8'h00, 0);

    // Timeout in PAY_LO, then recovery
    cycle(1, 8'h31, 0); cycle(1, 8'h12, 0);
    repeat (17) cycle(0, 8'h00, 0);
    cycle(1, 8'h10, 0);
    repeat (2) cycle(0, 8'h00, 0);

    // Unknown opcode; START-looking payload byte
    cycle(1, 8'h9F, 0);
    repeat (2) cycle(0, 8'h00, 0);
    cycle(1, 8'h32, 0); cycle(1, 8'h10, 0); cycle(1, 8'h22, 0);
    repeat (3) cycle(0, 8'h00, 1);

    // Byte accepted on the last idle cycle before expiry wins
    cycle(1, 8'h3C, 0);
    repeat (T - 2) cycle(0, 8'h00, 0);
    cycle(1, 8'h5A, 0);
    repeat (T - 2) cycle(0, 8'h00, 0);
    cycle(1, 8'hA5, 1);
    repeat (2) cycle(0, 8'h00, 1);

    // Asynchronous reset while ISSUE holds a pending write
    cycle(1, 8'h37, 0); cycle(1, 8'h12, 0); cycle(1, 8'h34, 0);
    repeat (3) cycle(0, 8'h00, 0);
    #1 i_rst_n = 1'b0;
    #1;
    chk("async_rst_cfg_valid", o_cfg_valid, 0);
    chk("async_rst_outputs", all_outs(), 32'd0);
    chk("scoreboard_empty_at_reset", sb.size(), 0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    cycle(1, 8'h10, 0);
    repeat (2) cycle(0, 8'h00, 0);

    // Random byte streams with occasional long silences
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        repeat ($urandom_range(10, 18)) cycle(0, 8'h00, ($urandom_range(0, 2) != 0));
      end else begin
        rb = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 4) == 0) rb[7:4] = 4'h3;
        cycle(($urandom_range(0, 3) != 0), rb, ($urandom_range(0, 2) != 0));
      end
    end
    repeat (40) cycle(0, 8'h00, 1);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ila_cmd_sequencer.md
Name: ila_cmd_sequencer

Overview:
Byte-level command sequencer for the GateMate ILA host interface. It takes bytes from the UART receive path and decodes the upper nibble as opcode and the lower nibble as argument. Multi-byte config writes are sequenced, handed off to the ILA config register bank over a valid/ready handshake, and abandoned by a timeout. Single-cycle control strobes (start, ILA reset, readback request) go to the capture controller.

Parameters:
TIMEOUT_CYCLES, 1000000, idle cycles allowed between payload bytes before the command is abandoned (min 2)
CNT_W, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_byte_valid  in  1  received byte available
i_byte  in  8  received byte; [7:4] opcode, [3:0] argument
o_byte_ready  out  1  sequencer accepts byte this cycle
o_cfg_valid  out  1  config write pending
i_cfg_ready  in  1  config bank accepts write
o_cfg_addr  out  4  config register address
o_cfg_data  out  16  config write data
o_start  out  1  one-cycle capture start strobe
o_ila_rst  out  1  one-cycle ILA soft-reset strobe
o_rd_req  out  1  one-cycle readback request
o_rd_addr  out  4  readback address, valid with o_rd_req
o_err  out  1  one-cycle error strobe
o_err_code  out  2  01 unknown opcode, 10 timeout; held until next o_err
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n. All registers and outputs reset to 0. The FSM resets to IDLE.
- A byte transfers on i_byte_valid && o_byte_ready. o_byte_ready = 1 in IDLE, PAY_HI and PAY_LO; 0 in ISSUE.
- Opcodes:
  - 0x1 START: o_start=1 the cycle after accept.
  - 0x2 RST: o_ila_rst=1 the cycle after accept.
  - 0x3 CFG_WR: latch arg into o_cfg_addr, go to PAY_HI.
  - 0x4 RD: o_rd_req=1 and o_rd_addr=arg the cycle after accept.
  - 0x0 NOP: ignored, no strobe.
  - 0x5-0xF: o_err=1 and o_err_code=01 the cycle after accept.
- FSM:
  - IDLE: decode opcodes as above. Only 0x3 leaves IDLE.
  - PAY_HI: accepted byte goes to o_cfg_data[15:8]; go to PAY_LO. The byte is not decoded as an opcode.
  - PAY_LO: accepted byte goes to o_cfg_data[7:0]; go to ISSUE, and o_cfg_valid=1 from the next cycle.
  - ISSUE: hold o_cfg_valid, o_cfg_addr and o_cfg_data stable until i_cfg_ready. On the cycle o_cfg_valid && i_cfg_ready, go to IDLE; o_cfg_valid=0 the following cycle. i_cfg_ready already high on entry completes ISSUE in one cycle.
- Latency: strobes 1 cycle after accept. CFG_WR min 4 cycles from opcode accept to IDLE.
- Timeout:
  - Counter clears on entry to PAY_HI/PAY_LO and on every accepted payload byte.
  - Increments each cycle in PAY_HI/PAY_LO with no accept.
  - When it reaches TIMEOUT_CYCLES-1: go to IDLE, o_err=1, o_err_code=10, and the partial payload is discarded (o_cfg_valid stays 0).
  - If a byte is accepted in the same cycle the count reaches TIMEOUT_CYCLES-1, the byte wins and the counter clears.
  - No timeout in ISSUE; the config bank must eventually respond.
- o_cfg_data holds its last value after ISSUE; only meaningful while o_cfg_valid.
- Strobes never overlap; at most one strobe per accepted byte.
- Reset asserted mid-command drops the partial payload and clears any pending o_cfg_valid immediately (asynchronous).

Decomposition:
- Package ila_cmd_pkg:
  - opcode localparams OP_NOP=0, OP_START=1, OP_RST=2, OP_CFG_WR=3, OP_RD=4
  - error code localparams ERR_OPC=2'b01, ERR_TMO=2'b10
  - FSM state encoding IDLE/PAY_HI/PAY_LO/ISSUE
- One sub-module, ila_cmd_timeout: counter with clear/enable inputs and an expire output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset, then bytes 0x10, 0x20, 0x47 back-to-back -> o_start, o_ila_rst, o_rd_req each high exactly one cycle in order; o_rd_addr=7 with o_rd_req; o_busy stays 0.
- Bytes 0x35, 0xAB, 0xCD with i_cfg_ready=1 -> o_cfg_valid for one cycle with o_cfg_addr=5, o_cfg_data=0xABCD; o_byte_ready low during ISSUE.
- Same as previous but i_cfg_ready low for 10 cycles -> o_cfg_valid and data held stable for 11 cycles; a byte offered during ISSUE is not accepted; after handshake it is accepted in IDLE.
- TIMEOUT_CYCLES=16: byte 0x31 then 0x12 then silence -> after 15 idle cycles o_err=1, o_err_code=10, return to IDLE, no o_cfg_valid. Next 0x10 yields o_start.
- Byte 0x9F -> o_err=1, o_err_code=01, FSM stays in IDLE. Payload byte 0x10 sent inside CFG_WR is not decoded as START.
- Assert i_rst_n=0 while in ISSUE with o_cfg_valid=1 -> o_cfg_valid drops asynchronously; all outputs 0; FSM in IDLE after release.
